// File: rtl/bsmul_pkg.sv
// rtl/bsmul_pkg.sv - shared types, defaults and parameter checks for bitserial_multiply
//
// Purpose : FSM state encoding, default operand widths and the helper that
//           validates the bits-per-cycle parameter against the multiplier width.
// Ports   : none (package)
package bsmul_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } bsmul_state_e;

  localparam int BSMUL_DEF_A_W = 8;
  localparam int BSMUL_DEF_B_W = 8;
  localparam int BSMUL_DEF_BPC = 1;

  // The multiplier is consumed in whole slices, so BPC must tile B_W exactly.
  function automatic bit bpc_divides(input int b_w, input int bpc);
    return (bpc >= 1) && (bpc <= b_w) && ((b_w % bpc) == 0);
  endfunction

endpackage

// File: rtl/bsmul_pp_slice.sv
// rtl/bsmul_pp_slice.sv - combinational partial product of a_ext and one multiplier slice
//
// Purpose : pp_o = a_ext_i * slice_i (mod 2^P_W). When neg_msb_i is set the
//           slice MSB carries negative weight (two's complement sign bit of the
//           original multiplier), so its shifted multiplicand is subtracted.
// Ports   : a_ext_i   [P_W-1:0] multiplicand, already sign/zero extended
//           slice_i   [BPC-1:0] current multiplier bits, LSB first
//           neg_msb_i           slice MSB is the multiplier sign bit
//           pp_o      [P_W-1:0] unshifted partial product
module bsmul_pp_slice
  import bsmul_pkg::*;
#(
  parameter int P_W = 2 * BSMUL_DEF_A_W,
  parameter int BPC = BSMUL_DEF_BPC
) (
  input  logic [P_W-1:0] a_ext_i,
  input  logic [BPC-1:0] slice_i,
  input  logic           neg_msb_i,
  output logic [P_W-1:0] pp_o
);

  logic [P_W-1:0] pp_acc;

  always_comb begin
    pp_acc = '0;
    for (int i = 0; i < BPC; i++) begin
      if (slice_i[i]) begin
        if ((i == BPC - 1) && neg_msb_i) begin
          pp_acc = pp_acc - (a_ext_i << i);
        end else begin
          pp_acc = pp_acc + (a_ext_i << i);
        end
      end
    end
    pp_o = pp_acc;
  end

endmodule

// File: rtl/bitserial_multiply.sv
// rtl/bitserial_multiply.sv - iterative shift-add multiplier, BPC multiplier bits per cycle
//
// Purpose : accepts a/b/is_signed on an in_valid/in_ready handshake, accumulates
//           one partial product per RUN cycle and presents the exact P_W-bit
//           product on an out_valid/out_ready handshake.
// Config  : BSMUL_ZERO_SKIP_EN - when defined, RUN finishes as soon as the
//           remaining multiplier bits are all zero (data-dependent latency).
// Ports   : clk, rstn (async active-low)
//           in_valid, in_ready, a [A_W-1:0], b [B_W-1:0], is_signed
//           out_valid, out_ready, result [P_W-1:0]
//           busy (high in RUN or DONE)
module bitserial_multiply
  import bsmul_pkg::*;
#(
  parameter int A_W = BSMUL_DEF_A_W,
  parameter int B_W = BSMUL_DEF_B_W,
  parameter int BPC = BSMUL_DEF_BPC
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [A_W-1:0]       a,
  input  logic [B_W-1:0]       b,
  input  logic                 is_signed,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [A_W+B_W-1:0]   result,
  output logic                 busy
);

  localparam int P_W    = A_W + B_W;
  localparam int K      = B_W / BPC;
  localparam int STEP_W = (K > 1) ? $clog2(K) : 1;

  generate
    if (!bpc_divides(B_W, BPC) || (A_W < 2) || (B_W < 2)) begin : g_bad_params
      $error("bitserial_multiply: BPC must divide B_W and A_W, B_W must be >= 2");
    end
  endgenerate

  bsmul_state_e      state_q, state_d;
  logic [P_W-1:0]    a_ext_q, a_ext_d;
  logic [B_W-1:0]    b_q, b_d;
  logic              signed_q, signed_d;
  logic [P_W-1:0]    acc_q, acc_d;
  logic [STEP_W-1:0] step_q, step_d;
  logic [P_W-1:0]    result_q, result_d;
  logic              out_valid_q, out_valid_d;

  logic              last_step;
  logic              skip;
  logic              finish;
  logic [31:0]       shamt;
  logic [P_W-1:0]    pp;
  logic [P_W-1:0]    pp_shifted;

  assign last_step  = (step_q == STEP_W'(K - 1));
  assign shamt      = 32'(step_q) * 32'(BPC);
  assign pp_shifted = pp << shamt;

`ifdef BSMUL_ZERO_SKIP_EN
  // b_q is shifted logically, so a negative signed multiplier keeps its sign
  // bit in b_q until the final slice and can never trigger the early exit.
  assign skip = (b_q == '0);
`else
  assign skip = 1'b0;
`endif

  assign finish = last_step | skip;

  bsmul_pp_slice #(
    .P_W (P_W),
    .BPC (BPC)
  ) u_pp_slice (
    .a_ext_i   (a_ext_q),
    .slice_i   (b_q[BPC-1:0]),
    .neg_msb_i (signed_q & last_step),
    .pp_o      (pp)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= IDLE;
      a_ext_q     <= '0;
      b_q         <= '0;
      signed_q    <= 1'b0;
      acc_q       <= '0;
      step_q      <= '0;
      result_q    <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_ext_q     <= a_ext_d;
      b_q         <= b_d;
      signed_q    <= signed_d;
      acc_q       <= acc_d;
      step_q      <= step_d;
      result_q    <= result_d;
      out_valid_q <= out_valid_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    a_ext_d     = a_ext_q;
    b_d         = b_q;
    signed_d    = signed_q;
    acc_d       = acc_q;
    step_d      = step_q;
    result_d    = result_q;
    out_valid_d = out_valid_q;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_ext_d  = is_signed ? {{B_W{a[A_W-1]}}, a} : {{B_W{1'b0}}, a};
          b_d      = b;
          signed_d = is_signed;
          acc_d    = '0;
          step_d   = '0;
          state_d  = RUN;
        end
      end
      RUN: begin
        acc_d  = acc_q + pp_shifted;
        b_d    = b_q >> BPC;
        step_d = step_q + 1'b1;
        if (finish) begin
          // The final partial product lands in the result on the same edge.
          result_d    = acc_d;
          out_valid_d = 1'b1;
          state_d     = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign out_valid = out_valid_q;
  assign result    = result_q;

endmodule
